seg_display_mux: RTL and testbench

- Time-multiplexed, parametrised N-digit hexadecimal seven-segment display driver.
- Successor to the single-digit combinational seven_seg_decoder. Shows a full multi-nibble value (e.g. PC plus accumulator) on a common-segment, per-digit-anode display.
- Adds the following over the single-digit decoder: capture register, scan counter, anti-ghosting guard interval, leading-zero blanking and per-digit decimal points.
- Clocked from the board's fast clock, not the divided CPU clock.

---
 rtl/seg_display_mux.sv | 93 +++++++++
 tb/tb_seg_display_mux.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed N-digit hex seven-segment driver with
// shadow capture, anti-ghosting guard, leading-zero blanking and decimal points.
module seg_display_mux #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 16,
  parameter int GUARD          = 1,
  parameter bit ACTIVE_LOW_SEG = 1,
  parameter bit ACTIVE_LOW_AN  = 1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0]        SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = ACTIVE_LOW_SEG;
  localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0]   val_q, val_d;
  logic [DIGITS-1:0]     dps_q, dps_d;
  logic [REFRESH_DIV-1:0] cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [DIGITS-1:0]     lz, an_l;
  logic [3:0]            nib;
  logic [6:0]            pat;
  logic                  zrun, dpb, bl;

  always_comb begin
    val_d = load ? value : val_q;
    dps_d = load ? dp_in : dps_q;
    cnt_d = cnt_q + REFRESH_DIV'(1);
    idx_d = &cnt_q ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
    zrun  = 1'b1;
    lz    = '0;
    nib   = '0;
    dpb   = 1'b0;
    bl    = 1'b0;
    // lz[i]: every nibble and dp bit from i up to the top digit is clear
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun  = zrun & (val_q[4*i +: 4] == 4'h0) & ~dps_q[i];
      lz[i] = zrun;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib = val_q[4*i +: 4];
        dpb = dps_q[i];
        bl  = blank_lz && i != 0 && lz[i];
      end
    end
    pat   = bl ? 7'h00 : SEG_LUT[nib];
    an_l  = (GUARD != 0 && cnt_q < REFRESH_DIV'(GUARD)) ? '0 : DIGITS'(1) << idx_q;
    seg_d = ACTIVE_LOW_SEG ? ~pat : pat;
    dp_d  = (dpb && !bl) ^ ACTIVE_LOW_SEG;
    an_d  = ACTIVE_LOW_AN ? ~an_l : an_l;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      val_q <= '0;
      dps_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
    end else begin
      val_q <= val_d;
      dps_q <= dps_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: vector table + cycle model scoreboard for the display driver,
// checking an active-low and an active-high instance side by side.
module tb_seg_display_mux;
  logic        clk = 1'b0, n_reset = 1'b0, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg, seg_h;
  logic        dp, dp_h;
  logic [3:0]  an, an_h;

  always #5 clk = ~clk;

  seg_display_mux #(.DIGITS(4), .REFRESH_DIV(2), .GUARD(1), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)) dut (
    .clk(clk), .n_reset(n_reset), .value(value), .load(load), .blank_lz(blank_lz),
    .dp_in(dp_in), .seg(seg), .dp(dp), .an(an));

  seg_display_mux #(.DIGITS(4), .REFRESH_DIV(2), .GUARD(1), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0)) dut_h (
    .clk(clk), .n_reset(n_reset), .value(value), .load(load), .blank_lz(blank_lz),
    .dp_in(dp_in), .seg(seg_h), .dp(dp_h), .an(an_h));

  typedef struct {logic [3:0] nib; logic [6:0] seg;} vec_t;
  typedef struct {logic [3:0] an; logic [6:0] seg; logic dp;} exp_t;

  vec_t        tbl[16];
  exp_t        sb[$];
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [1:0]  m_cnt = '0, m_idx = '0;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Predict the post-edge outputs from the model state, clock once, then check both DUTs.
  task automatic cycle();
    exp_t       e;
    logic [3:0] nib, ia;
    logic [6:0] is;
    logic       bl, id;
    nib = 4'(m_val >> (4 * m_idx));
    bl  = blank_lz && m_idx != 0 && (m_val >> (4 * m_idx)) == 0 && (m_dp >> m_idx) == 0;
    if (!n_reset) e = '{4'hF, 7'h7F, 1'b1};
    else begin
      e.an  = m_cnt == 0 ? 4'hF : ~(4'b1 << m_idx);
      e.seg = bl ? 7'h7F : ~tbl[nib].seg;
      e.dp  = bl ? 1'b1 : ~m_dp[m_idx];
    end
    sb.push_back(e);
    if (!n_reset) begin
      m_val = '0; m_dp = '0; m_cnt = '0; m_idx = '0;
    end else begin
      if (load) begin m_val = value; m_dp = dp_in; end
      if (m_cnt == 2'd3) m_idx = m_idx + 2'd1;
      m_cnt = m_cnt + 2'd1;
    end
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    ia = ~e.an;
    is = ~e.seg;
    id = ~e.dp;
    chk("an", an, e.an);
    chk("seg", seg, e.seg);
    chk("dp", dp, e.dp);
    chk("an_h", an_h, ia);
    chk("seg_h", seg_h, is);
    chk("dp_h", dp_h, id);
  endtask

  // Run n cycles; every lit cycle must show s[d]/dps[d] for the enabled digit.
  task automatic scan(input int n, input logic [3:0][6:0] s, input logic [3:0] dps);
    int lit[4] = '{default: 0};
    int g = 0;
    for (int c = 0; c < n; c++) begin
      cycle();
      if (an == 4'hF) g++;
      for (int d = 0; d < 4; d++) begin
        if (an == ~(4'b1 << d)) begin
          lit[d]++;
          chk("scan_seg", seg, s[d]);
          chk("scan_dp", dp, dps[d]);
        end
      end
    end
    chk("guard_count", 7'(g), 7'(n / 4));
    for (int d = 0; d < 4; d++) chk("lit_count", 7'(lit[d]), 7'(3 * n / 16));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [6:0] x;
    int         found;
    tbl[0]  = '{4'h0, 7'h3F}; tbl[1]  = '{4'h1, 7'h06}; tbl[2]  = '{4'h2, 7'h5B}; tbl[3]  = '{4'h3, 7'h4F};
    tbl[4]  = '{4'h4, 7'h66}; tbl[5]  = '{4'h5, 7'h6D}; tbl[6]  = '{4'h6, 7'h7D}; tbl[7]  = '{4'h7, 7'h07};
    tbl[8]  = '{4'h8, 7'h7F}; tbl[9]  = '{4'h9, 7'h6F}; tbl[10] = '{4'hA, 7'h77}; tbl[11] = '{4'hB, 7'h7C};
    tbl[12] = '{4'hC, 7'h39}; tbl[13] = '{4'hD, 7'h5E}; tbl[14] = '{4'hE, 7'h79}; tbl[15] = '{4'hF, 7'h71};

    n_reset = 1'b0; load = 1'b1; value = 16'hFFFF;
    repeat (3) begin
      cycle();
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
    end
    n_reset = 1'b1; load = 1'b0; value = '0;
    cycle();
    chk("rel_guard_an", an, 4'hF);
    chk("rel_seg", seg, 7'h40);
    cycle();
    chk("rel_an", an, 4'hE);

    value = 16'h1234; load = 1'b1;
    cycle();
    load = 1'b0;
    scan(32, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

    for (int k = 0; k < 16 && !(m_idx == 2'd0 && m_cnt == 2'd2); k++) cycle();
    chk("align", {3'b0, m_idx, m_cnt}, 7'h02);
    value = 16'h000A; load = 1'b1;
    cycle();
    chk("ld_old", seg, 7'h19);
    load = 1'b0;
    cycle();
    chk("ld_new", seg, 7'h08);

    value = 16'h0050; dp_in = 4'b0000; blank_lz = 1'b1; load = 1'b1;
    cycle();
    load = 1'b0;
    scan(16, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
    dp_in = 4'b0100; load = 1'b1;
    cycle();
    load = 1'b0;
    scan(16, {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1011);
    blank_lz = 1'b0;
    scan(16, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1011);

    found = 0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      if (an == 4'b1011) begin found = 1; break; end
    end
    chk("d2_found", 7'(found), 7'd1);
    n_reset = 1'b0;
    cycle();
    chk("mr_an", an, 4'hF);
    n_reset = 1'b1;
    cycle();
    chk("mr_guard", an, 4'hF);
    cycle();
    chk("mr_d0", an, 4'hE);
    chk("mr_seg", seg, 7'h40);

    dp_in = '0;
    for (int k = 0; k < 16; k++) begin
      value = {12'h000, tbl[k].nib}; load = 1'b1;
      cycle();
      load = 1'b0;
      found = 0;
      for (int j = 0; j < 16; j++) begin
        cycle();
        if (an == 4'hE) begin
          x = ~tbl[k].seg;
          chk("hex_seg", seg, x);
          chk("hex_seg_h", seg_h, tbl[k].seg);
          chk("hex_an_h", an_h, 4'h1);
          found = 1;
          break;
        end
      end
      chk("hex_found", 7'(found), 7'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
